// File: rtl/dp_pkg.sv
// Shared types and instruction-field layout for the sequenced datapath.
// Field offsets are measured from the instruction word MSB.
package dp_pkg;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_AND = 5'd2,
    OP_OR  = 5'd3,
    OP_SHR = 5'd4,
    OP_SHL = 5'd5,
    OP_NOT = 5'd6,
    OP_NEG = 5'd7,
    OP_MUL = 5'd8
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_DONE
  } state_e;

  localparam int OP_W    = 5;
  localparam int REG_W   = 4;
  localparam int RA_OFF  = 5;
  localparam int RB_OFF  = 9;
  localparam int RC_OFF  = 13;
  localparam int FIELD_W = 17;

  function automatic logic isLegal(input logic [4:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU: Y and B operands in, double-width result out.
// Only MUL produces a non-zero upper half.
module seq_alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   y,
  input  logic [DATA_W-1:0]   b,
  input  logic [4:0]          op,
  output logic [2*DATA_W-1:0] res
);
  import dp_pkg::*;

  localparam int SHW = $clog2(DATA_W);

  logic [SHW-1:0]      amt;
  logic [DATA_W-1:0]   low;
  logic [2*DATA_W-1:0] yExt;
  logic [2*DATA_W-1:0] bExt;

  assign amt  = b[SHW-1:0];
  // sign-extend so the truncated product is the signed full product
  assign yExt = {{DATA_W{y[DATA_W-1]}}, y};
  assign bExt = {{DATA_W{b[DATA_W-1]}}, b};

  always_comb begin
    low = '0;
    unique case (op)
      OP_ADD:  low = y + b;
      OP_SUB:  low = y - b;
      OP_AND:  low = y & b;
      OP_OR:   low = y | b;
      OP_SHR:  low = y >> amt;
      OP_SHL:  low = y << amt;
      OP_NOT:  low = ~b;
      OP_NEG:  low = -b;
      default: low = '0;
    endcase
  end

  assign res = (op == OP_MUL) ? yExt * bExt
                              : {{DATA_W{1'b0}}, low};

endmodule

// File: rtl/seq_datapath.sv
// Bus-style datapath with T-state sequencer: fetch in T0-T2,
// three-register ALU op in T3-T5, start/busy/done handshake.
module seq_datapath #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_sel,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  import dp_pkg::*;

  state_e              state;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   pc;
  logic [DATA_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   y;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [2*DATA_W-1:0] z;
  logic [2*DATA_W-1:0] aluRes;
  logic                illegalQ;

  logic [4:0]        irOp;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;
  logic [DATA_W-1:0] rbVal;
  logic [DATA_W-1:0] rcVal;
  logic [DATA_W-1:0] dbgVal;
  logic              unusedIr;

  assign irOp = ir[DATA_W-1 -: OP_W];
  assign ra   = ir[DATA_W-1-RA_OFF -: REG_W];
  assign rb   = ir[DATA_W-1-RB_OFF -: REG_W];
  assign rc   = ir[DATA_W-1-RC_OFF -: REG_W];
  assign unusedIr = ^ir[DATA_W-FIELD_W-1:0];

  // indices beyond NUM_REGS never match, so they read as zero
  always_comb begin
    rbVal  = '0;
    rcVal  = '0;
    dbgVal = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rb == 4'(i)) rbVal = regs[i];
      if (rc == 4'(i)) rcVal = regs[i];
      if (dbg_sel == 4'(i)) dbgVal = regs[i];
    end
  end

  seq_alu #(.DATA_W(DATA_W)) uAlu (
    .y   (y),
    .b   (rcVal),
    .op  (irOp),
    .res (aluRes)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_IDLE;
      pc       <= PC_RESET;
      mar      <= '0;
      mdr      <= '0;
      ir       <= '0;
      y        <= '0;
      z        <= '0;
      hi       <= '0;
      lo       <= '0;
      illegalQ <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          state    <= S_T0;
          illegalQ <= 1'b0;
        end
        S_T0: begin
          mar   <= pc;
          z     <= {{DATA_W{1'b0}}, pc + 1'b1};
          state <= S_T1;
        end
        S_T1: if (mem_ack) begin
          mdr   <= mem_rdata;
          pc    <= z[DATA_W-1:0];
          state <= S_T2;
        end
        S_T2: begin
          ir <= mdr;
          if (isLegal(mdr[DATA_W-1 -: OP_W])) begin
            state <= S_T3;
          end else begin
            state    <= S_DONE;
            illegalQ <= 1'b1;
          end
        end
        S_T3: begin
          y     <= rbVal;
          state <= S_T4;
        end
        S_T4: begin
          z     <= aluRes;
          state <= S_T5;
        end
        S_T5: begin
          if (irOp == OP_MUL) begin
            hi <= z[2*DATA_W-1:DATA_W];
            lo <= z[DATA_W-1:0];
          end
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // debug writes only land in IDLE, T5 writeback only in T5
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (state == S_IDLE && dbg_we && dbg_sel == 4'(i))
          regs[i] <= dbg_wdata;
        else if (state == S_T5 && ra == 4'(i))
          regs[i] <= z[DATA_W-1:0];
      end
    end
  end

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign illegal  = illegalQ;
  assign mem_read = (state == S_T1);
  assign mem_addr = mar;
  assign dbg_data = dbgVal;
  assign pc_out   = pc;
  assign hi_out   = hi;
  assign lo_out   = lo;

endmodule
